// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code tables, state encodings and key-classification helpers
// for the keyboard entry path.
package ps2_pkg;

  localparam logic [7:0] ENTER     = 8'h5A;
  localparam logic [7:0] BKSP      = 8'h66;
  localparam logic [7:0] ESC       = 8'h76;
  localparam logic [7:0] BREAK_PFX = 8'hF0;
  localparam logic [7:0] EXT_PFX   = 8'hE0;

  localparam logic [7:0] LETTER_CODES [0:9] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B
  };
  localparam logic [7:0] DIGIT_CODES [0:9] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };

  typedef enum logic [1:0] {
    WAIT_LETTER = 2'd0,
    WAIT_DIGITS = 2'd1,
    WAIT_ENTER  = 2'd2
  } entry_state_e;

  typedef enum logic {
    FR_IDLE  = 1'b0,
    FR_SHIFT = 1'b1
  } frame_state_e;

  // Returns {hit, value}; value is the table index when hit is set.
  function automatic logic [4:0] letter_of(input logic [7:0] code);
    logic [4:0] r;
    r = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (code == LETTER_CODES[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  function automatic logic [4:0] digit_of(input logic [7:0] code);
    logic [4:0] r;
    r = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (code == DIGIT_CODES[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame deserialiser with parity, framing
// and inter-bit timeout checks.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 27000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          ck_s1_q, ck_s1_d, ck_s2_q, ck_s2_d;
  logic          dt_s1_q, dt_s1_d, dt_s2_q, dt_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  frame_state_e  state_q, state_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_error_q, frame_error_d;
  logic          fall;

  always_comb begin
    ck_s1_d       = ps2_clk;
    ck_s2_d       = ck_s1_q;
    dt_s1_d       = ps2_data;
    dt_s2_d       = dt_s1_q;
    filt_d        = filt_q;
    filt_cnt_d    = '0;
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    par_d         = par_q;
    to_cnt_d      = to_cnt_q;
    byte_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    fall          = 1'b0;

    // Filtered clock follows the synchronised line only after a full run of
    // FILTER_LEN samples that disagree with it.
    if (ck_s2_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = ck_s2_q;
        fall   = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end

    case (state_q)
      FR_IDLE: begin
        if (fall) begin
          if (!dt_s2_q) begin
            state_d   = FR_SHIFT;
            bit_idx_d = 4'd1;
            to_cnt_d  = '0;
          end else begin
            frame_error_d = 1'b1;
          end
        end
      end
      FR_SHIFT: begin
        // A bit arriving on the expiry cycle takes priority over the timeout.
        if (fall) begin
          to_cnt_d  = '0;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q <= 4'd8) begin
            shift_d = {dt_s2_q, shift_q[7:1]};
          end else if (bit_idx_q == 4'd9) begin
            par_d = dt_s2_q;
          end else begin
            state_d = FR_IDLE;
            if ((^shift_q ^ par_q) && dt_s2_q) byte_valid_d  = 1'b1;
            else                               frame_error_d = 1'b1;
          end
        end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d       = FR_IDLE;
          frame_error_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = FR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ck_s1_q       <= 1'b1;
      ck_s2_q       <= 1'b1;
      dt_s1_q       <= 1'b1;
      dt_s2_q       <= 1'b1;
      filt_q        <= 1'b1;
      filt_cnt_q    <= '0;
      state_q       <= FR_IDLE;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      to_cnt_q      <= '0;
      byte_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      ck_s1_q       <= ck_s1_d;
      ck_s2_q       <= ck_s2_d;
      dt_s1_q       <= dt_s1_d;
      dt_s2_q       <= dt_s2_d;
      filt_q        <= filt_d;
      filt_cnt_q    <= filt_cnt_d;
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      to_cnt_q      <= to_cnt_d;
      byte_valid_q  <= byte_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign rx_byte     = shift_q;
  assign byte_valid  = byte_valid_q;
  assign frame_error = frame_error_q;

endmodule

// File: rtl/ps2_key_entry.sv
// PS/2 keyboard front end: make/break decoding with typematic suppression and
// a letter + digits + Enter entry sequencer for the game logic.
module ps2_key_entry
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 27000,
  parameter int NUM_DIGITS  = 2
) (
  input  logic                    clock27,
  input  logic                    resetN,
  input  logic                    keyboardClock,
  input  logic                    keyboardData,
  output logic [7:0]              scanCode,
  output logic                    scanValid,
  output logic                    keyPressed,
  output logic                    frameError,
  output logic [3:0]              letter,
  output logic [4*NUM_DIGITS-1:0] number,
  output logic                    entryValid,
  output logic [1:0]              entryState
);

  localparam int NW = 4 * NUM_DIGITS;

  logic [7:0] rx_byte;
  logic       byte_valid;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk        (clock27),
    .rst_n      (resetN),
    .ps2_clk    (keyboardClock),
    .ps2_data   (keyboardData),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_error(frameError)
  );

  logic          brk_q, brk_d, ext_q, ext_d;
  logic [7:0]    held_q, held_d;
  logic          key_pressed_q, key_pressed_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          scan_valid_q, scan_valid_d;
  entry_state_e  state_q, state_d;
  logic [3:0]    letter_q, letter_d;
  logic [NW-1:0] number_q, number_d;
  logic [2:0]    count_q, count_d;
  logic          entry_valid_q, entry_valid_d;
  logic [4:0]    lh, dh;

  always_comb begin
    brk_d         = brk_q;
    ext_d         = ext_q;
    held_d        = held_q;
    key_pressed_d = key_pressed_q;
    scan_code_d   = scan_code_q;
    scan_valid_d  = 1'b0;
    state_d       = state_q;
    letter_d      = letter_q;
    number_d      = number_q;
    count_d       = count_q;
    entry_valid_d = 1'b0;
    lh            = letter_of(scan_code_q);
    dh            = digit_of(scan_code_q);

    if (byte_valid) begin
      if (rx_byte == BREAK_PFX) begin
        brk_d = 1'b1;
      end else if (rx_byte == EXT_PFX) begin
        ext_d = 1'b1;
      end else if (ext_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (brk_q) begin
        if (rx_byte == held_q) key_pressed_d = 1'b0;
        brk_d = 1'b0;
      end else if (!(key_pressed_q && rx_byte == held_q)) begin
        scan_code_d   = rx_byte;
        scan_valid_d  = 1'b1;
        held_d        = rx_byte;
        key_pressed_d = 1'b1;
      end
    end

    if (scan_valid_q) begin
      if (scan_code_q == ESC) begin
        state_d  = WAIT_LETTER;
        number_d = '0;
        count_d  = '0;
      end else begin
        case (state_q)
          WAIT_LETTER: begin
            if (lh[4]) begin
              letter_d = lh[3:0];
              number_d = '0;
              count_d  = '0;
              state_d  = WAIT_DIGITS;
            end
          end
          WAIT_DIGITS: begin
            if (dh[4]) begin
              number_d = (number_q << 4) | NW'(dh[3:0]);
              count_d  = count_q + 3'd1;
              if (count_q + 3'd1 == 3'(NUM_DIGITS)) state_d = WAIT_ENTER;
            end else if (scan_code_q == BKSP) begin
              // Backspace on an empty digit field abandons the letter too.
              if (count_q != '0) begin
                number_d = number_q >> 4;
                count_d  = count_q - 3'd1;
              end else begin
                state_d = WAIT_LETTER;
              end
            end
          end
          WAIT_ENTER: begin
            if (scan_code_q == ENTER) begin
              entry_valid_d = 1'b1;
              state_d       = WAIT_LETTER;
            end else if (scan_code_q == BKSP) begin
              number_d = number_q >> 4;
              count_d  = count_q - 3'd1;
              state_d  = WAIT_DIGITS;
            end
          end
          default: state_d = WAIT_LETTER;
        endcase
      end
    end
  end

  always_ff @(posedge clock27) begin
    if (!resetN) begin
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
      held_q        <= '0;
      key_pressed_q <= 1'b0;
      scan_code_q   <= '0;
      scan_valid_q  <= 1'b0;
      state_q       <= WAIT_LETTER;
      letter_q      <= '0;
      number_q      <= '0;
      count_q       <= '0;
      entry_valid_q <= 1'b0;
    end else begin
      brk_q         <= brk_d;
      ext_q         <= ext_d;
      held_q        <= held_d;
      key_pressed_q <= key_pressed_d;
      scan_code_q   <= scan_code_d;
      scan_valid_q  <= scan_valid_d;
      state_q       <= state_d;
      letter_q      <= letter_d;
      number_q      <= number_d;
      count_q       <= count_d;
      entry_valid_q <= entry_valid_d;
    end
  end

  assign scanCode   = scan_code_q;
  assign scanValid  = scan_valid_q;
  assign keyPressed = key_pressed_q;
  assign letter     = letter_q;
  assign number     = number_q;
  assign entryValid = entry_valid_q;
  assign entryState = state_q;

endmodule

// File: tb/tb_ps2_key_entry.sv
// Directed bench for ps2_key_entry with shortened filter/timeout and a fast
// PS/2 clock so that every frame fits in a few hundred clock27 cycles.
`timescale 1ns/100ps
module tb_ps2_key_entry;

  localparam int FLEN = 4;
  localparam int TOUT = 300;
  localparam int HALF = 12;
  localparam int IDLE = 40;

  logic       clock27 = 1'b0;
  logic       resetN = 1'b0;
  logic       kb_clk = 1'b1;
  logic       kb_data = 1'b1;
  logic [7:0] scanCode;
  logic       scanValid, keyPressed, frameError, entryValid;
  logic [3:0] letter;
  logic [7:0] number;
  logic [1:0] entryState;

  int n_tests = 0;
  int n_fail = 0;
  int sv_cnt = 0;
  int fe_cnt = 0;
  int ev_cnt = 0;

  ps2_key_entry #(
    .FILTER_LEN (FLEN),
    .TIMEOUT_CYC(TOUT),
    .NUM_DIGITS (2)
  ) dut (
    .clock27      (clock27),
    .resetN       (resetN),
    .keyboardClock(kb_clk),
    .keyboardData (kb_data),
    .scanCode     (scanCode),
    .scanValid    (scanValid),
    .keyPressed   (keyPressed),
    .frameError   (frameError),
    .letter       (letter),
    .number       (number),
    .entryValid   (entryValid),
    .entryState   (entryState)
  );

  always #18.5 clock27 = ~clock27;

  always @(negedge clock27) begin
    if (scanValid === 1'b1) sv_cnt++;
    if (frameError === 1'b1) fe_cnt++;
    if (entryValid === 1'b1) ev_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock27);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kb_data = f[i];
      wait_cyc(HALF);
      kb_clk = 1'b0;
      wait_cyc(HALF);
      kb_clk = 1'b1;
    end
    wait_cyc(HALF);
    kb_data = 1'b1;
    wait_cyc(IDLE);
  endtask

  task automatic send_key(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic tap(input logic [7:0] b);
    send_key(b);
    send_key(8'hF0);
    send_key(b);
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    wait_cyc(5);
    n_tests++;
    if ({scanCode, scanValid, keyPressed, frameError, letter, number, entryValid} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h exp 0", {scanCode, scanValid, keyPressed, frameError, letter, number, entryValid});
    end
    n_tests++;
    if (entryState !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state got %0d exp 0", entryState);
    end
    resetN = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_make_break;
    int sv0;
    sv0 = sv_cnt;
    send_key(8'h1C);
    n_tests++;
    if (scanCode !== 8'h1C || keyPressed !== 1'b1) begin
      n_fail++;
      $display("FAIL make_1c got code=%h kp=%b exp code=1c kp=1", scanCode, keyPressed);
    end
    send_key(8'hF0);
    send_key(8'h1C);
    n_tests++;
    if (keyPressed !== 1'b0) begin
      n_fail++;
      $display("FAIL break_1c keyPressed got %b exp 0", keyPressed);
    end
    n_tests++;
    if (sv_cnt - sv0 !== 1) begin
      n_fail++;
      $display("FAIL make_break_pulses got %0d exp 1", sv_cnt - sv0);
    end
  endtask

  task automatic test_entry;
    int ev0;
    logic [7:0] keys [4];
    logic [1:0] exp_st [4];
    keys = '{8'h1C, 8'h16, 8'h1E, 8'h5A};
    exp_st = '{2'd1, 2'd1, 2'd2, 2'd0};
    tap(8'h76);
    n_tests++;
    if (entryState !== 2'd0) begin
      n_fail++;
      $display("FAIL esc_to_letter state got %0d exp 0", entryState);
    end
    ev0 = ev_cnt;
    for (int i = 0; i < 4; i++) begin
      tap(keys[i]);
      n_tests++;
      if (entryState !== exp_st[i]) begin
        n_fail++;
        $display("FAIL entry_state_step%0d got %0d exp %0d", i, entryState, exp_st[i]);
      end
    end
    n_tests++;
    if (ev_cnt - ev0 !== 1 || letter !== 4'd0 || number !== 8'h12) begin
      n_fail++;
      $display("FAIL entry_a12 got ev=%0d letter=%0d number=%h exp ev=1 letter=0 number=12", ev_cnt - ev0, letter, number);
    end
  endtask

  task automatic test_backspace;
    int ev0;
    ev0 = ev_cnt;
    tap(8'h21);
    tap(8'h16);
    tap(8'h66);
    n_tests++;
    if (entryState !== 2'd1 || number !== 8'h00) begin
      n_fail++;
      $display("FAIL bksp_first got state=%0d number=%h exp state=1 number=00", entryState, number);
    end
    tap(8'h66);
    n_tests++;
    if (entryState !== 2'd0) begin
      n_fail++;
      $display("FAIL bksp_empty state got %0d exp 0", entryState);
    end
    tap(8'h23);
    tap(8'h25);
    tap(8'h2E);
    tap(8'h5A);
    n_tests++;
    if (ev_cnt - ev0 !== 1 || letter !== 4'd3 || number !== 8'h45 || entryState !== 2'd0) begin
      n_fail++;
      $display("FAIL entry_d45 got ev=%0d letter=%0d number=%h st=%0d exp ev=1 letter=3 number=45 st=0", ev_cnt - ev0, letter, number, entryState);
    end
  endtask

  task automatic test_parity_error;
    int sv0, fe0;
    sv0 = sv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 11);
    n_tests++;
    if (fe_cnt - fe0 !== 1 || sv_cnt - sv0 !== 0 || entryState !== 2'd0) begin
      n_fail++;
      $display("FAIL parity_err got fe=%0d sv=%0d st=%0d exp fe=1 sv=0 st=0", fe_cnt - fe0, sv_cnt - sv0, entryState);
    end
    tap(8'h32);
    n_tests++;
    if (scanCode !== 8'h32 || letter !== 4'd1) begin
      n_fail++;
      $display("FAIL after_parity got code=%h letter=%0d exp code=32 letter=1", scanCode, letter);
    end
  endtask

  task automatic test_timeout;
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 5);
    wait_cyc(TOUT + FLEN + 4);
    n_tests++;
    if (fe_cnt - fe0 !== 1) begin
      n_fail++;
      $display("FAIL timeout_err got %0d exp 1", fe_cnt - fe0);
    end
    tap(8'h1E);
    n_tests++;
    if (scanCode !== 8'h1E || number !== 8'h02 || fe_cnt - fe0 !== 1) begin
      n_fail++;
      $display("FAIL after_timeout got code=%h number=%h fe=%0d exp code=1e number=02 fe=1", scanCode, number, fe_cnt - fe0);
    end
  endtask

  task automatic test_glitch;
    int fe0, sv0;
    fe0 = fe_cnt;
    sv0 = sv_cnt;
    kb_clk = 1'b0;
    wait_cyc(FLEN - 2);
    kb_clk = 1'b1;
    wait_cyc(IDLE);
    n_tests++;
    if (fe_cnt - fe0 !== 0 || sv_cnt - sv0 !== 0) begin
      n_fail++;
      $display("FAIL glitch got fe=%0d sv=%0d exp fe=0 sv=0", fe_cnt - fe0, sv_cnt - sv0);
    end
    tap(8'h1E);
    n_tests++;
    if (entryState !== 2'd2 || number !== 8'h22) begin
      n_fail++;
      $display("FAIL after_glitch got st=%0d number=%h exp st=2 number=22", entryState, number);
    end
  endtask

  task automatic test_enter_edit;
    tap(8'h66);
    n_tests++;
    if (entryState !== 2'd1 || number !== 8'h02) begin
      n_fail++;
      $display("FAIL bksp_in_enter got st=%0d number=%h exp st=1 number=02", entryState, number);
    end
    tap(8'h76);
    n_tests++;
    if (entryState !== 2'd0 || number !== 8'h00) begin
      n_fail++;
      $display("FAIL esc_clear got st=%0d number=%h exp st=0 number=00", entryState, number);
    end
  endtask

  task automatic test_typematic;
    int sv0;
    sv0 = sv_cnt;
    send_key(8'h1C);
    send_key(8'h1C);
    send_key(8'h1C);
    n_tests++;
    if (sv_cnt - sv0 !== 1 || keyPressed !== 1'b1 || scanCode !== 8'h1C) begin
      n_fail++;
      $display("FAIL typematic got sv=%0d kp=%b code=%h exp sv=1 kp=1 code=1c", sv_cnt - sv0, keyPressed, scanCode);
    end
    send_key(8'hF0);
    send_key(8'h1C);
  endtask

  task automatic test_extended;
    int sv0;
    sv0 = sv_cnt;
    send_key(8'hE0);
    send_key(8'h1C);
    n_tests++;
    if (sv_cnt - sv0 !== 0 || keyPressed !== 1'b0) begin
      n_fail++;
      $display("FAIL extended got sv=%0d kp=%b exp sv=0 kp=0", sv_cnt - sv0, keyPressed);
    end
    tap(8'h32);
    n_tests++;
    if (sv_cnt - sv0 !== 1 || scanCode !== 8'h32) begin
      n_fail++;
      $display("FAIL after_extended got sv=%0d code=%h exp sv=1 code=32", sv_cnt - sv0, scanCode);
    end
  endtask

  task automatic test_reset_midframe;
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 5);
    resetN = 1'b0;
    wait_cyc(3);
    resetN = 1'b1;
    wait_cyc(1);
    n_tests++;
    if ({scanCode, keyPressed, letter, number, entryState} !== 23'h0) begin
      n_fail++;
      $display("FAIL midframe_reset got %h exp 0", {scanCode, keyPressed, letter, number, entryState});
    end
    wait_cyc(TOUT + 100);
    n_tests++;
    if (fe_cnt - fe0 !== 0) begin
      n_fail++;
      $display("FAIL midframe_no_err got %0d exp 0", fe_cnt - fe0);
    end
    send_key(8'h1C);
    n_tests++;
    if (scanCode !== 8'h1C || entryState !== 2'd1) begin
      n_fail++;
      $display("FAIL after_midframe got code=%h st=%0d exp code=1c st=1", scanCode, entryState);
    end
  endtask

  initial begin
    test_reset;
    test_make_break;
    test_entry;
    test_backspace;
    test_parity_error;
    test_timeout;
    test_glitch;
    test_enter_edit;
    test_typematic;
    test_extended;
    test_reset_midframe;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
